// File: rtl/matbi_axil_ctrl_master_if.sv
// rtl/matbi_axil_ctrl_master_if.sv - AXI4-Lite bus bundle between the control master and a register slave
interface matbi_axil_ctrl_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic                    M_BREADY;
  logic [ADDR_WIDTH-1:0]   M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;
  logic                    M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARVALID, input M_ARREADY,
    input M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    input M_AWADDR, M_AWVALID, output M_AWREADY,
    input M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface

// File: rtl/matbi_axil_ctrl_master.sv
// rtl/matbi_axil_ctrl_master.sv - single-outstanding command/response to AXI4-Lite master
// Holds each bus transaction until the slave answers; a stall counter only flags, never aborts.
module matbi_axil_ctrl_master #(
  parameter int          C_M_AXI_ADDR_WIDTH = 6,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic                            timeout_err,
  matbi_axil_ctrl_master_if.master        m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d, to_q, to_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            stall;

  assign cmd_ready   = (state_q == IDLE) && !ARESET;
  assign busy        = (state_q != IDLE);
  assign stall       = (state_q == WADDR) || (state_q == WRESP) ||
                       (state_q == RADDR) || (state_q == RDATA);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign timeout_err = to_q;

  assign m_axi.M_AWADDR  = addr_q;
  assign m_axi.M_AWVALID = awvalid_q;
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = wstrb_q;
  assign m_axi.M_WVALID  = wvalid_q;
  assign m_axi.M_BREADY  = bready_q;
  assign m_axi.M_ARADDR  = addr_q;
  assign m_axi.M_ARVALID = arvalid_q;
  assign m_axi.M_RREADY  = rready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
        cnt_d   = '0;
        to_d    = 1'b0;
        if (cmd_write) begin
          state_d   = WADDR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RADDR;
          arvalid_d = 1'b1;
        end
      end
      // A low VALID inside WADDR doubles as that channel's done flag.
      WADDR: begin
        if (awvalid_q && m_axi.M_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: if (m_axi.M_BVALID && bready_q) begin
        bready_d    = 1'b0;
        resp_d      = m_axi.M_BRESP;
        rdata_d     = '0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RADDR: if (m_axi.M_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RDATA;
      end
      RDATA: if (m_axi.M_RVALID) begin
        rready_d    = 1'b0;
        rdata_d     = m_axi.M_RDATA;
        resp_d      = m_axi.M_RRESP;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stall) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if ((TIMEOUT_CYCLES != 16'd0) && (cnt_d == TIMEOUT_CYCLES)) to_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
    end
  end
endmodule

// File: tb/tb_matbi_axil_ctrl_master.sv
// tb/tb_matbi_axil_ctrl_master.sv - scoreboard bench with a register-file slave model
module tb_matbi_axil_ctrl_master;
  localparam int AW = 6;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;

  matbi_axil_ctrl_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) axi ();

  matbi_axil_ctrl_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err),
    .m_axi(axi)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0, fails = 0;
  int          cyc = 0, acc_cyc = 0;
  logic [31:0] model_mem [16];
  logic [31:0] slv_mem [16];
  int          cfg_da = 0, cfg_dw = 0, cfg_db = 0, cfg_dar = 0, cfg_dr = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [5:0]  cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: per-channel ready delays, register file storage, bus-stability checks.
  initial begin : slave
    int aw_wait, w_wait, ar_wait, b_wait, r_wait, aw_cnt, w_cnt;
    bit b_pend, b_fire, r_pend, r_fire;
    logic p_awv, p_wv, p_arv;
    logic [5:0] p_awaddr, p_araddr, ar_addr_s;
    logic [31:0] p_wdata, w_data_s;
    logic [3:0] p_wstrb, w_strb_s;
    axi.M_AWREADY = 0; axi.M_WREADY = 0; axi.M_ARREADY = 0;
    axi.M_BVALID = 0; axi.M_BRESP = 0; axi.M_RVALID = 0; axi.M_RDATA = 0; axi.M_RRESP = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; aw_cnt = 0; w_cnt = 0;
    b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
    ar_addr_s = 0; w_data_s = 0; w_strb_s = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        axi.M_AWREADY = 0; axi.M_WREADY = 0; axi.M_ARREADY = 0; axi.M_BVALID = 0; axi.M_RVALID = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; aw_cnt = 0; w_cnt = 0;
        b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0; p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (p_awv) begin
          if (axi.M_AWREADY) chk("awvalid_drop", axi.M_AWVALID, 0);
          else begin
            chk("awvalid_hold", axi.M_AWVALID, 1);
            chk("awaddr_stable", axi.M_AWADDR, p_awaddr);
          end
        end
        if (p_wv) begin
          if (axi.M_WREADY) chk("wvalid_drop", axi.M_WVALID, 0);
          else begin
            chk("wvalid_hold", axi.M_WVALID, 1);
            chk("wdata_stable", axi.M_WDATA, p_wdata);
            chk("wstrb_stable", axi.M_WSTRB, p_wstrb);
          end
        end
        if (p_arv) begin
          if (axi.M_ARREADY) chk("arvalid_drop", axi.M_ARVALID, 0);
          else begin
            chk("arvalid_hold", axi.M_ARVALID, 1);
            chk("araddr_stable", axi.M_ARADDR, p_araddr);
          end
        end
        p_awv = axi.M_AWVALID; p_awaddr = axi.M_AWADDR;
        p_wv = axi.M_WVALID; p_wdata = axi.M_WDATA; p_wstrb = axi.M_WSTRB;
        p_arv = axi.M_ARVALID; p_araddr = axi.M_ARADDR;

        if (b_fire) begin
          axi.M_BVALID = 0; b_fire = 0;
        end else if (b_pend) begin
          if (!axi.M_BVALID) begin
            if (b_wait >= cfg_db) begin axi.M_BVALID = 1; axi.M_BRESP = cfg_resp; end
            else b_wait++;
          end
          if (axi.M_BVALID && axi.M_BREADY) begin
            chk("one_aw_per_b", aw_cnt, 1);
            chk("one_w_per_b", w_cnt, 1);
            for (int b = 0; b < 4; b++)
              if (w_strb_s[b]) slv_mem[p_awaddr[5:2]][8*b +: 8] = w_data_s[8*b +: 8];
            aw_cnt = 0; w_cnt = 0; b_pend = 0; b_fire = 1;
          end
        end
        if (r_fire) begin
          axi.M_RVALID = 0; r_fire = 0;
        end else if (r_pend) begin
          if (!axi.M_RVALID) begin
            if (r_wait >= cfg_dr) begin
              axi.M_RVALID = 1; axi.M_RDATA = slv_mem[ar_addr_s[5:2]]; axi.M_RRESP = cfg_resp;
            end else r_wait++;
          end
          if (axi.M_RVALID && axi.M_RREADY) begin r_pend = 0; r_fire = 1; end
        end

        axi.M_AWREADY = 0;
        if (axi.M_AWVALID) begin
          if (aw_wait >= cfg_da) begin
            axi.M_AWREADY = 1; aw_cnt++;
            chk("awaddr", axi.M_AWADDR, cur_addr);
          end else aw_wait++;
        end else aw_wait = 0;
        axi.M_WREADY = 0;
        if (axi.M_WVALID) begin
          if (w_wait >= cfg_dw) begin
            axi.M_WREADY = 1; w_cnt++;
            w_data_s = axi.M_WDATA; w_strb_s = axi.M_WSTRB;
            chk("wdata", w_data_s, cur_wdata);
            chk("wstrb", w_strb_s, cur_wstrb);
          end else w_wait++;
        end else w_wait = 0;
        if (aw_cnt > 0 && w_cnt > 0 && !b_pend && !b_fire) begin b_pend = 1; b_wait = 0; end
        axi.M_ARREADY = 0;
        if (axi.M_ARVALID) begin
          if (ar_wait >= cfg_dar) begin
            axi.M_ARREADY = 1; ar_addr_s = axi.M_ARADDR; r_pend = 1; r_wait = 0;
            chk("araddr", axi.M_ARADDR, cur_addr);
          end else ar_wait++;
        end else ar_wait = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each rsp handshake.
  initial begin : rsp_mon
    bit seen, held;
    logic [31:0] h_rdata;
    logic [1:0] h_resp;
    exp_t e;
    seen = 0; held = 0; h_rdata = 0; h_resp = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        seen = 0; held = 0;
      end else if (rsp_valid) begin
        chk("cmd_ready_low_in_rsp", cmd_ready, 0);
        chk("busy_in_rsp", busy, 1);
        if (!seen) begin
          seen = 1;
          if (exp_q.size() > 0 && exp_q[0].chk_lat) chk("rsp_latency", cyc - acc_cyc, exp_q[0].lat);
        end
        if (held) begin
          chk("rsp_rdata_stable", rsp_rdata, h_rdata);
          chk("rsp_resp_stable", rsp_resp, h_resp);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("timeout_err", timeout_err, e.to);
          end
          seen = 0; held = 0;
        end else begin
          held = 1; h_rdata = rsp_rdata; h_resp = rsp_resp;
        end
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n = 0;
    @(posedge ACLK); #1;
    cur_addr = addr; cur_wdata = data; cur_wstrb = strb;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    @(negedge ACLK);
    while (!cmd_ready && n < 300) begin n++; @(negedge ACLK); end
    if (n >= 300) chk("cmd_accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge ACLK); #1 cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int hold);
    int n = 0;
    @(negedge ACLK);
    while (!rsp_valid && n < 300) begin n++; @(negedge ACLK); end
    if (n >= 300) begin chk("rsp_wait_timeout", 0, 1); return; end
    repeat (hold) @(posedge ACLK);
    @(posedge ACLK); #1 rsp_ready = 1;
    @(posedge ACLK); #1 rsp_ready = 0;
  endtask

  task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d1, input int d2, input int d3,
                         input logic [1:0] resp, input int hold);
    exp_t e;
    cfg_resp = resp;
    e.resp = resp; e.to = 0; e.chk_lat = 1;
    if (wr) begin
      cfg_da = d1; cfg_dw = d2; cfg_db = d3;
      e.lat = ((d1 > d2) ? d1 : d2) + d3 + 3;
      e.rdata = 0;
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    end else begin
      cfg_dar = d1; cfg_dr = d2;
      e.lat = d1 + d2 + 3;
      e.rdata = model_mem[addr[5:2]];
    end
    exp_q.push_back(e);
    send_cmd(wr, addr, data, strb);
    wait_rsp(hold);
  endtask

  initial begin : main
    exp_t e;
    int n;
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin model_mem[i] = $urandom; slv_mem[i] = model_mem[i]; end
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    @(negedge ACLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_ARVALID, axi.M_BREADY, axi.M_RREADY}, 0);

    run_txn(1, 6'h10, 32'hDEADBEEF, 4'hF, 0, 1, 0, 2'b00, 0);
    run_txn(1, 6'h24, 32'h00000005, 4'hF, 0, 0, 0, 2'b00, 0);
    run_txn(0, 6'h24, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1);
    run_txn(0, 6'h10, 32'h0, 4'h0, 1, 2, 0, 2'b00, 0);
    run_txn(1, 6'h08, 32'hA5A5A5A5, 4'h5, 3, 0, 1, 2'b00, 0);
    run_txn(1, 6'h04, 32'h13572468, 4'hF, 0, 0, 0, 2'b10, 5);

    // Slave never takes AR: timeout flags but the read stays pending.
    cfg_dar = 1000; cfg_dr = 0; cfg_resp = 2'b00;
    e.rdata = model_mem[2]; e.resp = 2'b00; e.to = 1; e.lat = 0; e.chk_lat = 0;
    exp_q.push_back(e);
    send_cmd(0, 6'h08, 32'h0, 4'h0);
    repeat (4) @(negedge ACLK);
    chk("timeout_not_early", timeout_err, 0);
    repeat (8) @(negedge ACLK);
    chk("timeout_set", timeout_err, 1);
    chk("timeout_arvalid_held", axi.M_ARVALID, 1);
    chk("timeout_busy", busy, 1);
    #2 cfg_dar = 0;
    wait_rsp(0);
    run_txn(0, 6'h24, 32'h0, 4'h0, 0, 0, 0, 2'b01, 0);

    // Reset while waiting for B.
    cfg_da = 0; cfg_dw = 0; cfg_db = 1000;
    send_cmd(1, 6'h0C, 32'h12345678, 4'hF);
    n = 0;
    @(negedge ACLK);
    while (!axi.M_BREADY && n < 50) begin n++; @(negedge ACLK); end
    chk("reached_wresp", axi.M_BREADY, 1);
    @(posedge ACLK); #1 ARESET = 1;
    @(posedge ACLK); #1 ARESET = 0;
    @(negedge ACLK);
    chk("rst_mid_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_ARVALID, axi.M_BREADY, axi.M_RREADY}, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    cfg_db = 0;
    run_txn(0, 6'h0C, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), {4'($urandom_range(0, 15)), 2'b00}, $urandom,
              4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge ACLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
